serial_frame_rx: RTL
====================

# serial_frame_rx

Frame receiver that sits directly downstream of the last `data_path` stage and consumes its single-bit serial output. It hunts for a sync word in the bit stream, assembles the following payload bits into WIDTH-bit words, and buffers them in a small FIFO behind a valid/ready interface. The core is clocked on the non-inverted `clk` domain that the final `data_path` stage also uses.

## Interface
- `WIDTH`, 8: word and sync-word width in bits, ≥ 2.
- `SYNC_WORD`, 8'hA5: WIDTH-bit frame delimiter.
- `FRAME_WORDS`, 4: payload words per frame, ≥ 1.
- `FIFO_DEPTH`, 4: output buffer entries, power of two, ≥ 2.

Ports (name, direction, width, meaning):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `in`  in  1  serial bit from upstream `data_path`.
- `in_en`  in  1  `in` is a valid bit this cycle.
- `out_data`  out  WIDTH  FIFO head word.
- `out_sof`  out  1  head word is the first payload word of its frame.
- `out_valid`  out  1  FIFO not empty.
- `out_ready`  in  1  consumer accepts head word.
- `locked`  out  1  receiver is in frame (DATA or CHECK).
- `overflow`  out  1  sticky: a word was dropped on a full FIFO.

## Operation
- Bit accept: `in_en`=1 at a rising edge. Shift register `sh <= {sh[WIDTH-2:0], in}`, MSB first. Bits with `in_en`=0 are ignored; all counters hold.
- FSM states: HUNT, DATA, CHECK.
  - HUNT: on each accepted bit, compare the *next* `sh` value to SYNC_WORD. On a match, go to DATA and clear the bit and word counters. Matching is bit-sliding, so any alignment is valid.
  - DATA: count WIDTH accepted bits. On the WIDTHth bit, push the next `sh` value with `sof` = (word counter == 0), then increment the word counter. After word FRAME_WORDS-1 is pushed, go to CHECK.
  - CHECK: collect WIDTH bits. If they equal SYNC_WORD, go to DATA with counters cleared. Otherwise go to HUNT; no word is pushed.
- `locked` = 1 in DATA or CHECK.
- FIFO push and pop:
  - Pop when `out_valid && out_ready`.
  - A push when full and not popping is dropped and sets `overflow`. `overflow` clears only on reset.
  - Simultaneous push and pop when full: both succeed, no overflow.
  - Simultaneous push and pop when empty: not possible, because `out_valid`=0.
- `out_data` and `out_sof` come from registered FIFO storage. They are stable while `out_valid && !out_ready`.
- Counter widths are clog2 of their range. Pointers wrap modulo FIFO_DEPTH, plus one extra bit for full/empty detection.

## Timing
- Reset (async assert, sync release inside the block is not required):
  - state = HUNT, `sh` = 0, counters = 0.
  - FIFO empty, storage = 0.
  - `out_valid` = 0, `out_data` = 0, `out_sof` = 0, `locked` = 0, `overflow` = 0.
- Reset mid-frame discards partial word, FIFO contents and lock.
- Latency: if the FIFO is empty, a word is visible with `out_valid`=1 immediately after the edge that accepts its last bit.
- `locked` rises after the edge accepting the last sync bit. It falls after the edge completing a failed CHECK.
- A pop at edge N exposes the next entry (or `out_valid`=0) after edge N.
- Throughput: one word per WIDTH accepted bits. The FIFO never stalls the bit input.

## Structure
- Package `serial_frame_rx_pkg`: FSM state enum `rx_state_t` (HUNT, DATA, CHECK) and a `rx_word_t` struct {sof, data} sized by WIDTH via parameterised typedef in the module.
- Sub-module `sync_fifo` (WIDTH+1 data bits, DEPTH, push/pop/full/empty, async active-low reset). The framing FSM, shift register and counters live in `serial_frame_rx`.

## Test plan
All scenarios use WIDTH=8, SYNC_WORD=8'hA5, FRAME_WORDS=2, FIFO_DEPTH=4.
- Reset: hold `rst`=0, toggle `in` → all outputs 0, `locked`=0.
- Lock and assemble: stream A5,3C,C3,A5,11,22 with `in_en`=1 and `out_ready`=1 → words 3C(sof=1), C3(sof=0), 11(sof=1), 22(sof=0). `locked` stays 1 from the edge after the 8th bit.
- Misalignment and gaps: 3 junk bits, then the same stream with `in_en` toggling 1/0 → identical words; no word before the sync.
- CHECK fail: A5,3C,C3,5A → words 3C, C3; `locked` drops after the 32nd bit; later A5 relocks.
- Backpressure: `out_ready`=0, send 3 full frames (6 words) → first 4 words retained in order, `overflow`=1. Raise `out_ready` → 4 words drain, then `out_valid`=0.
- Reset mid-frame: assert `rst` after 5 bits of word 2 → FIFO empty, HUNT. After release, a fresh A5,3C,… frame decodes correctly.

Source files
------------

// File: rtl/serial_frame_rx_pkg.sv
// serial_frame_rx_pkg: shared types for the serial frame receiver.
package serial_frame_rx_pkg;

    typedef enum logic [1:0] {HUNT, DATA, CHECK} rx_state_t;

endpackage

// File: rtl/serial_frame_rx_sync_fifo.sv
// sync_fifo: registered-storage FIFO with extra-bit pointers for full/empty.
module sync_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp, rp;
    logic         do_push, do_pop;

    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a full FIFO still takes a word when the head leaves on the same edge
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rp[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp  <= '0;
            rp  <= '0;
            mem <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wp[AW-1:0]] <= din;
                wp              <= wp + 1'b1;
            end
            if (do_pop)
                rp <= rp + 1'b1;
        end
    end

endmodule

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: hunts a sync word in a serial stream, assembles payload
// words and buffers them behind a valid/ready interface.
module serial_frame_rx
    import serial_frame_rx_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] SYNC_WORD   = 8'hA5,
    parameter int               FRAME_WORDS = 4,
    parameter int               FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    input  logic             in_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic             overflow
);

    localparam int BW = $clog2(WIDTH);
    localparam int CW = FRAME_WORDS > 1 ? $clog2(FRAME_WORDS) : 1;

    typedef struct packed {
        logic             sof;
        logic [WIDTH-1:0] data;
    } rx_word_t;

    rx_state_t        state, state_nxt;
    logic [WIDTH-1:0] sh, sh_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [CW-1:0]    word_cnt, word_nxt;
    logic             last_bit, push, pop, full, empty;
    rx_word_t         push_word, head;

    assign sh_nxt   = {sh[WIDTH-2:0], in};
    assign last_bit = bit_cnt == BW'(WIDTH - 1);

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        word_nxt  = word_cnt;
        push      = 1'b0;
        push_word = '{sof: word_cnt == '0, data: sh_nxt};
        if (in_en) begin
            case (state)
                HUNT: if (sh_nxt == SYNC_WORD) begin
                    state_nxt = DATA;
                    bit_nxt   = '0;
                    word_nxt  = '0;
                end
                DATA: begin
                    bit_nxt = last_bit ? '0 : bit_cnt + 1'b1;
                    if (last_bit) begin
                        push      = 1'b1;
                        word_nxt  = word_cnt + 1'b1;
                        if (word_cnt == CW'(FRAME_WORDS - 1)) begin
                            state_nxt = CHECK;
                            word_nxt  = '0;
                        end
                    end
                end
                CHECK: begin
                    bit_nxt = last_bit ? '0 : bit_cnt + 1'b1;
                    // a missing trailing sync word drops lock; no word is pushed
                    if (last_bit)
                        state_nxt = sh_nxt == SYNC_WORD ? DATA : HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= HUNT;
            sh       <= '0;
            bit_cnt  <= '0;
            word_cnt <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            bit_cnt  <= bit_nxt;
            word_cnt <= word_nxt;
            if (in_en)
                sh <= sh_nxt;
            if (push && full && !pop)
                overflow <= 1'b1;
        end
    end

    assign pop       = out_valid && out_ready;
    assign out_valid = !empty;
    assign out_data  = head.data;
    assign out_sof   = head.sof;
    assign locked    = state != HUNT;

    sync_fifo #(
        .W     (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_word),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

endmodule
